// File: rtl/exec_pkg.sv
// Shared constants and ALU opcode encoding for the execute/register/memory slice.
package exec_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_NREGS     = 8;
    localparam int DEF_MEM_WORDS = 8;
    localparam int ADDR_W        = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_NOT = 3'b010,
        ALU_SLL = 3'b011,
        ALU_SRL = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/exec_alu.sv
// Purely combinational ALU; add/sub wrap, shifts saturate to zero past the word width.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic               shift_big;
    logic [SHAMT_W-1:0] shamt;

    // Any set bit above the shift-amount field means the shift clears the word.
    assign shift_big = |b[DATA_W-1:SHAMT_W];
    assign shamt     = b[SHAMT_W-1:0];

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_NOT: y = ~a;
            ALU_SLL: y = shift_big ? '0 : (a << shamt);
            ALU_SRL: y = shift_big ? '0 : (a >> shamt);
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, (a < b)};
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/exec_regmem_slice.sv
// Register file, ALU and small data memory; all state clears on synchronous reset.
module exec_regmem_slice
    import exec_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NREGS     = DEF_NREGS,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              reg_write,
    input  logic              alu_src,
    input  logic [DATA_W-1:0] imm,
    input  logic [2:0]        alu_ctrl,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              mem_to_reg,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] mem_q  [MEM_WORDS];
    logic [DATA_W-1:0] mem_d  [MEM_WORDS];

    logic [DATA_W-1:0] alu_b;
    logic [ADDR_W-1:0] mem_addr;

    // Reads see the stored value only, so a same-cycle write is not bypassed.
    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];
    assign alu_b     = alu_src ? imm : rd_data_b;

    exec_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a    (rd_data_a),
        .b    (alu_b),
        .op   (alu_op_e'(alu_ctrl)),
        .y    (alu_result),
        .zero (zero)
    );

    assign mem_addr  = alu_result[ADDR_W-1:0];
    assign mem_rdata = mem_read ? mem_q[mem_addr] : '0;
    assign wb_data   = mem_to_reg ? mem_rdata : alu_result;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg_next
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (reg_write && (wr_addr == ADDR_W'(gi))) begin
                    regs_d[gi] = wb_data;
                end
            end
        end
        for (genvar gi = 0; gi < MEM_WORDS; gi++) begin : g_mem_next
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (mem_write && (mem_addr == ADDR_W'(gi))) begin
                    mem_d[gi] = rd_data_b;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: tb/tb_exec_regmem_slice.sv
// Directed bench for exec_regmem_slice with hand-computed expectations.
module tb_exec_regmem_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic        reg_write, alu_src, mem_write, mem_read, mem_to_reg;
    logic [15:0] imm;
    logic [2:0]  alu_ctrl;
    logic [15:0] rd_data_a, rd_data_b, alu_result, mem_rdata, wb_data;
    logic        zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exec_regmem_slice dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .wr_addr    (wr_addr),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .imm        (imm),
        .alu_ctrl   (alu_ctrl),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .alu_result (alu_result),
        .zero       (zero),
        .mem_rdata  (mem_rdata),
        .wb_data    (wb_data)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        rd_addr_a  = 3'd0;
        rd_addr_b  = 3'd0;
        wr_addr    = 3'd0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        imm        = 16'h0000;
        alu_ctrl   = 3'b000;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
    endtask

    // Loads a register as R0 + imm through the ALU write-back path.
    task automatic load_reg(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        idle_inputs();
        alu_src   = 1'b1;
        imm       = v;
        reg_write = 1'b1;
        wr_addr   = a;
        #1;
        chk("load_wb", wb_data, v);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    // Sets an ALU op with A=Ra and B either imm or Rb, then samples.
    task automatic alu_step(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                            input logic src, input logic [15:0] im);
        @(negedge clk);
        idle_inputs();
        alu_ctrl  = op;
        rd_addr_a = ra;
        rd_addr_b = rb;
        alu_src   = src;
        imm       = im;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_alu", alu_result, 16'h0000);
        chk("rst_zero", {15'd0, zero}, 16'h0001);
        chk("rst_mem", mem_rdata, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Every register and memory word must read zero after reset.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_inputs();
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(i);
            alu_ctrl  = 3'b001;
            #1;
            chk($sformatf("rst_ra%0d", i), rd_data_a, 16'h0000);
            chk($sformatf("rst_rb%0d", i), rd_data_b, 16'h0000);
            chk($sformatf("rst_z%0d", i), {15'd0, zero}, 16'h0001);
            rd_addr_a = 3'd0;
            alu_src   = 1'b1;
            alu_ctrl  = 3'b000;
            imm       = 16'(i);
            mem_read  = 1'b1;
            #1;
            chk($sformatf("rst_mem%0d", i), mem_rdata, 16'h0000);
        end

        // Same-cycle read of the written register returns the old value.
        @(negedge clk);
        idle_inputs();
        alu_src   = 1'b1;
        imm       = 16'd5;
        reg_write = 1'b1;
        wr_addr   = 3'd1;
        rd_addr_b = 3'd1;
        #1;
        chk("nobypass_old", rd_data_b, 16'h0000);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        chk("nobypass_new", rd_data_b, 16'h0005);
        load_reg(3'd2, 16'd3);

        alu_step(3'b001, 3'd1, 3'd2, 1'b0, 16'h0);
        chk("sub_5_3", alu_result, 16'h0002);
        chk("sub_zero", {15'd0, zero}, 16'h0000);
        alu_step(3'b111, 3'd1, 3'd2, 1'b0, 16'h0);
        chk("slt_5_3", alu_result, 16'h0000);
        alu_step(3'b111, 3'd2, 3'd1, 1'b0, 16'h0);
        chk("slt_3_5", alu_result, 16'h0001);
        alu_step(3'b001, 3'd1, 3'd1, 1'b0, 16'h0);
        chk("sub_self", alu_result, 16'h0000);
        chk("sub_self_zero", {15'd0, zero}, 16'h0001);
        alu_step(3'b000, 3'd1, 3'd2, 1'b0, 16'h0);
        chk("add_5_3", alu_result, 16'h0008);
        alu_step(3'b101, 3'd1, 3'd2, 1'b0, 16'h0);
        chk("and_5_3", alu_result, 16'h0001);
        alu_step(3'b110, 3'd1, 3'd2, 1'b0, 16'h0);
        chk("or_5_3", alu_result, 16'h0007);
        alu_step(3'b001, 3'd0, 3'd1, 1'b0, 16'h0);
        chk("sub_wrap", alu_result, 16'hFFFB);
        load_reg(3'd3, 16'hFFFF);
        alu_step(3'b000, 3'd3, 3'd0, 1'b1, 16'h0001);
        chk("add_wrap", alu_result, 16'h0000);
        chk("add_wrap_zero", {15'd0, zero}, 16'h0001);

        // Shift boundaries.
        load_reg(3'd1, 16'h0001);
        alu_step(3'b011, 3'd1, 3'd0, 1'b1, 16'd4);
        chk("sll_4", alu_result, 16'h0010);
        alu_step(3'b011, 3'd1, 3'd0, 1'b1, 16'd16);
        chk("sll_16", alu_result, 16'h0000);
        alu_step(3'b011, 3'd1, 3'd0, 1'b1, 16'd15);
        chk("sll_15", alu_result, 16'h8000);
        alu_step(3'b011, 3'd1, 3'd0, 1'b1, 16'h0100);
        chk("sll_256", alu_result, 16'h0000);
        load_reg(3'd1, 16'h8000);
        alu_step(3'b100, 3'd1, 3'd0, 1'b1, 16'd15);
        chk("srl_15", alu_result, 16'h0001);
        alu_step(3'b100, 3'd1, 3'd0, 1'b1, 16'd16);
        chk("srl_16", alu_result, 16'h0000);
        load_reg(3'd1, 16'h0000);
        alu_step(3'b010, 3'd1, 3'd0, 1'b0, 16'h0);
        chk("not_0", alu_result, 16'hFFFF);

        // Store R2 at address 0xB, which wraps to word 3.
        load_reg(3'd2, 16'hABCD);
        @(negedge clk);
        idle_inputs();
        alu_src   = 1'b1;
        imm       = 16'h000B;
        rd_addr_b = 3'd2;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        #1;
        chk("st_old", mem_rdata, 16'h0000);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        chk("ld_3", mem_rdata, 16'hABCD);
        mem_read = 1'b0;
        #1;
        chk("ld_off", mem_rdata, 16'h0000);
        imm      = 16'h0003;
        mem_read = 1'b1;
        #1;
        chk("ld_3_direct", mem_rdata, 16'hABCD);

        // Load into R4 from memory.
        @(negedge clk);
        idle_inputs();
        alu_src    = 1'b1;
        imm        = 16'h000B;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        wr_addr    = 3'd4;
        rd_addr_b  = 3'd4;
        #1;
        chk("lw_wb", wb_data, 16'hABCD);
        chk("lw_old", rd_data_b, 16'h0000);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        chk("lw_new", rd_data_b, 16'hABCD);

        // Register and memory writes in the same cycle.
        @(negedge clk);
        idle_inputs();
        alu_src   = 1'b1;
        imm       = 16'h0005;
        rd_addr_b = 3'd2;
        mem_write = 1'b1;
        reg_write = 1'b1;
        wr_addr   = 3'd5;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b1;
        rd_addr_a = 3'd5;
        #1;
        chk("dual_reg", rd_data_a, 16'h0005);
        rd_addr_a = 3'd0;
        #1;
        chk("dual_mem", mem_rdata, 16'hABCD);

        // Reset wins over simultaneous writes.
        @(negedge clk);
        idle_inputs();
        rst       = 1'b1;
        alu_src   = 1'b1;
        imm       = 16'h0006;
        rd_addr_b = 3'd2;
        mem_write = 1'b1;
        reg_write = 1'b1;
        wr_addr   = 3'd6;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        rd_addr_a = 3'd6;
        rd_addr_b = 3'd4;
        #1;
        chk("rstprio_reg", rd_data_a, 16'h0000);
        chk("rstclr_r4", rd_data_b, 16'h0000);
        rd_addr_a = 3'd0;
        alu_src   = 1'b1;
        imm       = 16'h0006;
        mem_read  = 1'b1;
        #1;
        chk("rstprio_mem", mem_rdata, 16'h0000);
        imm = 16'h0003;
        #1;
        chk("rstclr_mem3", mem_rdata, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
